// File: rtl/inst_queue_pkg.sv
// Shared constants for the fetch -> decode instruction buffer.
// Pure declarations, no logic and no latency.
// The fetch stage and the decoder reuse these so all three agree on widths.
package inst_queue_pkg;

  // Architectural word width for pc and instruction.
  localparam int IQ_XLEN  = 32;
  // Default queue depth; must stay a power of two and at least 2.
  localparam int IQ_DEPTH = 8;
  // Index width into the storage array.
  localparam int IQ_PTR_W = $clog2(IQ_DEPTH);

  // One buffered fetch result, as handed from fetch to decode.
  typedef struct packed {
    logic [IQ_XLEN-1:0] pc;
    logic [IQ_XLEN-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode side bundle of the instruction queue: push, pop, flush and fill level.
// Wires only, no latency.
// push_ready / pop_valid carry the backpressure in each direction.
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int XLEN  = IQ_XLEN,
  parameter int PTR_W = IQ_PTR_W
);

  logic             flush;
  logic             push_valid;
  logic             push_ready;
  logic [XLEN-1:0]  push_pc;
  logic [XLEN-1:0]  push_inst;
  logic             pop_valid;
  logic             pop_ready;
  logic [XLEN-1:0]  pop_pc;
  logic [XLEN-1:0]  pop_inst;
  logic [PTR_W:0]   count;

  // Pipeline side: drives fetched words, consumes the head, sees the fill level.
  modport master (
    output flush, push_valid, push_pc, push_inst, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_inst, count
  );

  // Queue side.
  modport slave (
    input  flush, push_valid, push_pc, push_inst, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_inst, count
  );

endinterface

// File: rtl/inst_queue_mem.sv
// Entry storage: DEPTH x W register array, one write port and one read port.
// Write lands on the rising edge; read is combinational from raddr.
// No flow control here; the owner decides when we is safe.
module inst_queue_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Synchronous write; contents are never reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// In-order {pc, inst} buffer between fetch and decode, flushable in one cycle.
// Push-to-pop latency 1 cycle (no bypass); head is read combinationally.
// push_ready = !full from registered state only; a full queue refuses even with a same-cycle pop.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = IQ_PTR_W,
  parameter int XLEN  = IQ_XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_queue_if.slave  iq
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]     head_q;
  logic [PTR_W:0]     tail_q;
  logic [PTR_W:0]     count_q;
  logic               empty;
  logic               full;
  logic               push_fire;
  logic               pop_fire;
  logic [2*XLEN-1:0]  rd_dat;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                 (head_q[PTR_W] != tail_q[PTR_W]);

  // Flush wins over both handshakes, so neither side commits during it.
  assign push_fire = iq.push_valid && !full && !iq.flush;
  assign pop_fire  = iq.pop_ready && !empty && !iq.flush;

  inst_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W),
    .W     (2*XLEN)
  ) u_mem (
    .clk   (clk),
    .we    (push_fire),
    .waddr (tail_q[PTR_W-1:0]),
    .wdata ({iq.push_pc, iq.push_inst}),
    .raddr (head_q[PTR_W-1:0]),
    .rdata (rd_dat)
  );

  // Pointer and occupancy update; flush empties by pulling head up to tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (iq.flush) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      if (push_fire) tail_q <= tail_q + PTR_ONE;
      if (pop_fire)  head_q <= head_q + PTR_ONE;
      if (push_fire && !pop_fire)      count_q <= count_q + PTR_ONE;
      else if (pop_fire && !push_fire) count_q <= count_q - PTR_ONE;
    end
  end

  assign iq.push_ready = !full;
  assign iq.pop_valid  = !empty;
  // Stale array contents are masked so an empty queue always shows zeros.
  assign iq.pop_pc     = empty ? '0 : rd_dat[2*XLEN-1:XLEN];
  assign iq.pop_inst   = empty ? '0 : rd_dat[XLEN-1:0];
  assign iq.count      = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed table-driven bench for inst_queue plus hand-written async reset sequence.
module tb_inst_queue;

  logic clk;
  logic rst_n;

  inst_queue_if #(.XLEN(32), .PTR_W(3)) iq ();

  inst_queue #(.DEPTH(8), .PTR_W(3), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iq    (iq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        push_valid;
    logic [31:0] push_pc;
    logic [31:0] push_inst;
    logic        pop_ready;
    logic        e_pop_valid;
    logic [31:0] e_pop_pc;
    logic [31:0] e_pop_inst;
    logic        e_push_ready;
    logic [3:0]  e_count;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_err;

  function automatic void add(input logic fl, input logic pv, input logic [31:0] pc,
                              input logic [31:0] inst, input logic prd,
                              input logic epv, input logic [31:0] epc,
                              input logic [31:0] einst, input logic eprdy,
                              input logic [3:0] ecnt);
    vec_t v;
    v.flush = fl; v.push_valid = pv; v.push_pc = pc; v.push_inst = inst;
    v.pop_ready = prd; v.e_pop_valid = epv; v.e_pop_pc = epc; v.e_pop_inst = einst;
    v.e_push_ready = eprdy; v.e_count = ecnt;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic epv, input logic [31:0] epc,
                            input logic [31:0] einst, input logic eprdy, input logic [3:0] ecnt);
    check({tag, " pop_valid"},  {31'd0, iq.pop_valid},  {31'd0, epv});
    check({tag, " pop_pc"},     iq.pop_pc,              epc);
    check({tag, " pop_inst"},   iq.pop_inst,            einst);
    check({tag, " push_ready"}, {31'd0, iq.push_ready}, {31'd0, eprdy});
    check({tag, " count"},      {28'd0, iq.count},      {28'd0, ecnt});
  endtask

  // Inputs driven just after a rising edge, outputs sampled on the falling edge.
  task automatic apply(input vec_t v, input string tag);
    iq.flush      = v.flush;
    iq.push_valid = v.push_valid;
    iq.push_pc    = v.push_pc;
    iq.push_inst  = v.push_inst;
    iq.pop_ready  = v.pop_ready;
    @(negedge clk);
    check_outs(tag, v.e_pop_valid, v.e_pop_pc, v.e_pop_inst, v.e_push_ready, v.e_count);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iq.flush = 1'b0; iq.push_valid = 1'b0; iq.push_pc = '0;
    iq.push_inst = '0; iq.pop_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;

    // Single entry round trip.
    add(0, 0, 32'h0, 32'h0, 0,  0, 32'h0, 32'h0, 1, 4'd0);
    add(0, 1, 32'h0, 32'h13, 0, 0, 32'h0, 32'h0, 1, 4'd0);
    add(0, 0, 32'h0, 32'h0, 1,  1, 32'h0, 32'h13, 1, 4'd1);
    add(0, 0, 32'h0, 32'h0, 0,  0, 32'h0, 32'h0, 1, 4'd0);
    // Fill to 8, refuse a 9th, drain in order.
    for (int i = 0; i < 8; i++)
      add(0, 1, 32'(4*i), 32'h0010_0093 + 32'(i), 0,
          i > 0, 32'h0, (i > 0) ? 32'h0010_0093 : 32'h0, 1, 4'(i));
    add(0, 1, 32'h20, 32'hdead_beef, 0, 1, 32'h0, 32'h0010_0093, 0, 4'd8);
    for (int j = 0; j < 8; j++)
      add(0, 0, 32'h0, 32'h0, 1, 1, 32'(4*j), 32'h0010_0093 + 32'(j), j != 0, 4'(8-j));
    add(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 4'd0);
    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 8; i++)
      add(0, 1, 32'h40 + 32'(4*i), 32'h2000 + 32'(i), 0,
          i > 0, (i > 0) ? 32'h40 : 32'h0, (i > 0) ? 32'h2000 : 32'h0, 1, 4'(i));
    add(0, 1, 32'h60, 32'h2008, 1, 1, 32'h40, 32'h2000, 0, 4'd8);
    add(0, 1, 32'h60, 32'h2008, 0, 1, 32'h44, 32'h2001, 1, 4'd7);
    for (int j = 0; j < 8; j++)
      add(0, 0, 32'h0, 32'h0, 1, 1, 32'h44 + 32'(4*j), 32'h2001 + 32'(j), j != 0, 4'(8-j));
    add(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 4'd0);
    // Steady stream, pointers wrap repeatedly.
    for (int k = 0; k <= 20; k++)
      add(0, 1, 32'h100 + 32'(4*k), 32'h3000 + 32'(k), 1,
          k > 0, (k > 0) ? 32'h100 + 32'(4*(k-1)) : 32'h0,
          (k > 0) ? 32'h3000 + 32'(k-1) : 32'h0, 1, (k > 0) ? 4'd1 : 4'd0);
    add(0, 0, 32'h0, 32'h0, 1, 1, 32'h150, 32'h3014, 1, 4'd1);
    add(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 4'd0);
    // Flush with same-cycle push and pop.
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'h300 + 32'(4*i), 32'h4000 + 32'(i), 0,
          i > 0, (i > 0) ? 32'h300 : 32'h0, (i > 0) ? 32'h4000 : 32'h0, 1, 4'(i));
    add(1, 1, 32'h400, 32'h4444, 1, 1, 32'h300, 32'h4000, 1, 4'd5);
    add(0, 1, 32'h200, 32'h5000, 0, 0, 32'h0, 32'h0, 1, 4'd0);
    add(0, 0, 32'h0, 32'h0, 1, 1, 32'h200, 32'h5000, 1, 4'd1);
    add(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 4'd0);

    // Reset, released between edges.
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check_outs("in_reset", 1'b0, 32'h0, 32'h0, 1'b1, 4'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset with 3 entries held, asserted and released between edges.
    for (int i = 0; i < 3; i++) begin
      v.flush = 0; v.push_valid = 1; v.push_pc = 32'h600 + 32'(4*i);
      v.push_inst = 32'h6000 + 32'(i); v.pop_ready = 0;
      v.e_pop_valid = i > 0; v.e_pop_pc = (i > 0) ? 32'h600 : 32'h0;
      v.e_pop_inst = (i > 0) ? 32'h6000 : 32'h0; v.e_push_ready = 1; v.e_count = 4'(i);
      apply(v, $sformatf("rst_fill%0d", i));
    end
    idle_inputs();
    check_outs("pre_reset", 1'b1, 32'h600, 32'h6000, 1'b1, 4'd3);
    #1 rst_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 32'h0, 32'h0, 1'b1, 4'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    v.flush = 0; v.push_valid = 1; v.push_pc = 32'h500; v.push_inst = 32'h7000; v.pop_ready = 0;
    v.e_pop_valid = 0; v.e_pop_pc = 0; v.e_pop_inst = 0; v.e_push_ready = 1; v.e_count = 4'd0;
    apply(v, "post_rst_push");
    v.push_valid = 0; v.pop_ready = 1;
    v.e_pop_valid = 1; v.e_pop_pc = 32'h500; v.e_pop_inst = 32'h7000; v.e_count = 4'd1;
    apply(v, "post_rst_pop");
    v.pop_ready = 0;
    v.e_pop_valid = 0; v.e_pop_pc = 0; v.e_pop_inst = 0; v.e_count = 4'd0;
    apply(v, "post_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
